dmem_lsu: RTL and testbench

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_lsu.sv | 141 ++++++++++++++
 tb/tb_dmem_lsu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - byte-addressable data memory load/store unit with clear-after-reset
module dmem_lsu #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  // WAIT counts down to zero, so it is loaded with one less than its length
  localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  clr_cnt;
  logic [2:0]        wait_cnt;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              accept;
  logic              misaligned;
  logic [IDX_W-1:0]  word_idx;
  logic [3:0]        lane_en;
  logic [31:0]       wlanes;
  logic [31:0]       rd_word;
  logic [31:0]       shifted;
  logic [31:0]       load_data;
  logic [31:0]       mem [0:DEPTH-1];

  assign accept   = req_valid && (state == ST_IDLE);
  assign word_idx = req_addr[ADDR_W-1:2];
  assign rd_word  = mem[word_idx];

  // Alignment check, lane enables and lane-replicated store data for the request
  always_comb begin
    misaligned = 1'b0;
    lane_en    = 4'b0000;
    wlanes     = req_wdata;
    case (req_size)
      2'b00: begin
        lane_en = 4'b0001 << req_addr[1:0];
        wlanes  = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = req_addr[0];
        lane_en    = req_addr[1] ? 4'b1100 : 4'b0011;
        wlanes     = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        misaligned = |req_addr[1:0];
        lane_en    = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Extract the addressed byte/half from the word and sign- or zero-extend it
  always_comb begin
    shifted = rd_word >> {req_addr[1:0], 3'b000};
    case (req_size)
      2'b00:   load_data = {{24{~req_unsigned & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{~req_unsigned & shifted[15]}}, shifted[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_CLEAR;
    else        state <= state_nxt;
  end

  // FSM next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      ST_CLEAR: if (clr_cnt == LAST_IDX) state_nxt = ST_IDLE;
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: if (wait_cnt == 3'd0) state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // Clear/wait counters and the response captured at acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_cnt  <= '0;
      wait_cnt <= 3'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (accept) begin
        wait_cnt <= WAIT_LOAD;
        err_q    <= misaligned;
        rdata_q  <= (req_we || misaligned) ? 32'd0 : load_data;
      end else if (state == ST_WAIT && wait_cnt != 3'd0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
    end
  end

  // Memory array: zero-fill during CLEAR, lane-masked commit of accepted aligned stores
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_CLEAR) begin
        mem[clr_cnt] <= 32'd0;
      end else if (accept && req_we && !misaligned) begin
        for (int i = 0; i < 4; i++)
          if (lane_en[i]) mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
  assign rsp_err   = rsp_valid ? err_q : 1'b0;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - randomized self-checking bench for dmem_lsu against a byte-level memory model
module tb_dmem_lsu;

  localparam int ADDR_W = 6;
  localparam int WAIT_C = 3;
  localparam int NBYTES = 2 ** ADDR_W;
  localparam int DEPTH  = NBYTES / 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'd0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mb [NBYTES];

  dmem_lsu #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_C)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  // free-running clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // byte-addressed little-endian reference memory
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input int addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err);
    int nb;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || (addr % nb != 0);
    rd  = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) mb[addr + i] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) rd |= 32'(mb[addr + i]) << (8 * i);
        if (!uns && nb < 4 && rd[8*nb-1]) rd |= 32'hFFFF_FFFF << (8 * nb);
      end
    end
  endtask

  // called at a negedge; holds reset, checks quiet outputs, then times the CLEAR phase
  task automatic do_reset(input int hold, input string tag);
    int n;
    rst_n = 1'b0;
    req_valid = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, ":rst_ready"}, 32'(req_ready), 32'd0);
      check({tag, ":rst_rsp"}, {rsp_valid, rsp_err, rsp_rdata[29:0]}, 32'd0);
    end
    rst_n = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      n++;
      if (rsp_valid) check({tag, ":rsp_in_clear"}, 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    check({tag, ":clear_cycles"}, 32'(n), 32'(DEPTH));
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
  endtask

  // one request, called at a negedge; checks handshake timing and response
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input int addr, input logic [31:0] wdata, input string tag,
                        output logic [31:0] got);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          n;
    n = 0;
    while (!req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({tag, ":ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = ADDR_W'(addr); req_wdata = wdata;
    model(we, size, uns, addr, wdata, exp_rd, exp_err);
    @(negedge clk);
    // request fields change after acceptance; a held valid must be ignored while busy
    for (int k = 1; k <= WAIT_C; k++) begin
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'($urandom_range(0, 2));
      req_unsigned = 1'($urandom); req_addr = ADDR_W'($urandom); req_wdata = $urandom;
      check($sformatf("%s:wait%0d_rsp", tag, k), 32'(rsp_valid), 32'd0);
      check($sformatf("%s:wait%0d_ready", tag, k), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    got = rsp_rdata;
    check({tag, ":rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ":rsp_ready"}, 32'(req_ready), 32'd0);
    check({tag, ":rdata"}, rsp_rdata, exp_rd);
    check({tag, ":err"}, 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
    check({tag, ":after"}, {30'd0, rsp_valid, ~req_ready}, 32'd0);
    check({tag, ":after_data"}, {rsp_rdata[30:0], rsp_err}, 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    logic [1:0]  sz;
    int          a;

    @(negedge clk);
    // reset abandoned mid-CLEAR, then a full reset
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_reset(2, "por");

    // every word reads zero after CLEAR
    for (int w = 0; w < DEPTH; w++) begin
      do_req(1'b0, 2'd2, 1'b0, 4 * w, 32'd0, $sformatf("zero%0d", w), got);
      check($sformatf("zero%0d_lit", w), got, 32'd0);
    end

    do_req(1'b1, 2'd2, 1'b0, 'h10, 32'h8899AABB, "sw10", got);
    do_req(1'b0, 2'd0, 1'b0, 'h13, 32'd0, "lb13", got);
    check("lb13_lit", got, 32'hFFFFFF88);
    do_req(1'b0, 2'd0, 1'b1, 'h13, 32'd0, "lbu13", got);
    check("lbu13_lit", got, 32'h00000088);
    do_req(1'b0, 2'd1, 1'b0, 'h12, 32'd0, "lh12", got);
    check("lh12_lit", got, 32'hFFFF8899);

    do_req(1'b1, 2'd2, 1'b0, 'h20, 32'h11223344, "sw20", got);
    do_req(1'b1, 2'd0, 1'b0, 'h21, 32'hFFFFFF5A, "sb21", got);
    do_req(1'b0, 2'd2, 1'b0, 'h20, 32'd0, "lw20", got);
    check("lw20_lit", got, 32'h11225A44);

    do_req(1'b1, 2'd1, 1'b0, 'h03, 32'hFFFFFFFF, "sh03", got);
    do_req(1'b1, 2'd3, 1'b0, 'h00, 32'hFFFFFFFF, "ssz3", got);
    do_req(1'b0, 2'd3, 1'b1, 'h10, 32'd0, "lsz3", got);
    check("lsz3_lit", got, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 'h00, 32'd0, "lw00", got);
    check("lw00_lit", got, 32'd0);

    // randomized traffic against the byte model
    for (int t = 0; t < 400; t++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, NBYTES - 1);
      if ($urandom_range(0, 3) != 0) a = a & ~((sz == 2'd0) ? 0 : (sz == 2'd1) ? 1 : 3);
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, $sformatf("rnd%0d", t), got);
    end

    // reset during the second WAIT cycle of a pending load
    do_req(1'b1, 2'd2, 1'b0, 'h08, 32'hDEADBEEF, "sw08", got);
    check("pre_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 'h08;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_w1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("abort_w2", 32'(rsp_valid), 32'd0);
    do_reset(3, "abort");
    do_req(1'b0, 2'd2, 1'b0, 'h08, 32'd0, "lw08", got);
    check("lw08_lit", got, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // absolute time limit
  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
